// File: rtl/ahb_apb_bridge_ctrl.sv
// AHB-to-APB bridge controller: one AHB slave port fanned out to three APB slaves.
// Optional APB_PREADY_EN: honour PREADY wait states in ACCESS (default: one-cycle ACCESS).
module ahb_apb_bridge_ctrl (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic [1:0]  HTRANS,
    input  logic [31:0] HADDR,
    input  logic        HWRITE,
    input  logic [31:0] HWDATA,
    input  logic        HREADYin,
    output logic        HREADY_OUT,
    output logic [1:0]  HRESP,
    output logic [31:0] HRDATA,
    output logic [2:0]  PSEL,
    output logic        PENABLE,
    output logic        PWRITE,
    output logic [31:0] PADDR,
    output logic [31:0] PWDATA,
    input  logic [31:0] PRDATA,
    input  logic        PREADY
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WWAIT,
        ST_SETUP,
        ST_ACCESS
    } state_t;

    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    state_t     state, state_nxt;
    logic [2:0] sel_q, sel_nxt, sel_dec;
    logic       in_range;
    logic       accept;
    logic       complete;

`ifdef APB_PREADY_EN
    assign complete = PREADY;
`else
    logic unused_pready;
    assign unused_pready = PREADY;
    assign complete      = 1'b1;
`endif

    // Three 64 MB windows starting at 0x8000_0000; the fourth quarter is unmapped.
    assign in_range = (HADDR[31:28] == 4'h8) && (HADDR[27:26] != 2'b11);

    always_comb begin
        sel_dec = 3'b000;
        case (HADDR[27:26])
            2'b00:   sel_dec = 3'b001;
            2'b01:   sel_dec = 3'b010;
            2'b10:   sel_dec = 3'b100;
            default: sel_dec = 3'b000;
        endcase
    end

    assign HREADY_OUT = (state == ST_IDLE) || ((state == ST_ACCESS) && complete);
    assign HRESP      = 2'b00;
    assign HRDATA     = PRDATA;

    // An address phase is only taken while this bridge is not stalling the bus.
    assign accept = HREADY_OUT && HREADYin && in_range &&
                    ((HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ));

    // NOTE: every signal written here gets a default first, so no path leaves one unassigned (no latch).
    always_comb begin
        state_nxt = state;
        sel_nxt   = sel_q;
        unique case (state)
            ST_IDLE, ST_ACCESS: begin
                if (HREADY_OUT) begin
                    if (accept) begin
                        state_nxt = HWRITE ? ST_WWAIT : ST_SETUP;
                        sel_nxt   = sel_dec;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            ST_WWAIT: state_nxt = ST_SETUP;
            ST_SETUP: state_nxt = ST_ACCESS;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: state and registered outputs use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state   <= ST_IDLE;
            sel_q   <= 3'b000;
            PSEL    <= 3'b000;
            PENABLE <= 1'b0;
            PWRITE  <= 1'b0;
            PADDR   <= 32'h0;
            PWDATA  <= 32'h0;
        end else begin
            state   <= state_nxt;
            sel_q   <= sel_nxt;
            PSEL    <= ((state_nxt == ST_SETUP) || (state_nxt == ST_ACCESS)) ? sel_nxt : 3'b000;
            PENABLE <= (state_nxt == ST_ACCESS);
            if (accept) begin
                PADDR  <= HADDR;
                PWRITE <= HWRITE;
            end
            if (state == ST_WWAIT) begin
                PWDATA <= HWDATA;
            end
        end
    end

endmodule
